// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one DRAM slave port among NUM_PORTS bus masters.
// It keeps one transaction outstanding and routes read data back by source tag.
module mem_bus_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int SRC_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        cpu_req_valid,
    output logic [NUM_PORTS-1:0]        cpu_req_ready,
    input  logic [2*NUM_PORTS-1:0]      cpu_req_type,
    input  logic [ADDR_W*NUM_PORTS-1:0] cpu_req_addr,
    input  logic [DATA_W*NUM_PORTS-1:0] cpu_req_payload,
    output logic [NUM_PORTS-1:0]        cpu_resp_valid,
    output logic [DATA_W-1:0]           cpu_resp_payload,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [1:0]                  mem_req_type,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_payload,
    output logic [SRC_W-1:0]            mem_req_source,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_payload,
    input  logic [SRC_W-1:0]            mem_resp_source,
    output logic                        busy,
    output logic                        err_bad_cmd,
    output logic                        err_bad_resp
);
    localparam int         PTR_W      = $clog2(NUM_PORTS);
    localparam logic [1:0] TYPE_READ  = 2'b01;
    localparam logic [1:0] TYPE_WRITE = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]           type_q, type_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    payload_q, payload_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]    resp_payload_q, resp_payload_d;
    logic                 err_cmd_q, err_cmd_d;
    logic                 err_resp_q, err_resp_d;

    logic                 found;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     scan_idx;
    logic [1:0]           win_type;

    // First valid requester at or above rr_ptr, wrapping, wins the bus.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!found && cpu_req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        type_d         = type_q;
        addr_d         = addr_q;
        payload_d      = payload_q;
        src_d          = src_q;
        resp_valid_d   = '0;
        resp_payload_d = resp_payload_q;
        err_cmd_d      = err_cmd_q;
        err_resp_d     = err_resp_q;
        cpu_req_ready  = '0;
        win_type       = cpu_req_type[2*int'(winner) +: 2];

        case (state_q)
            IDLE: begin
                if (found) begin
                    cpu_req_ready[winner] = 1'b1;
                    type_d    = win_type;
                    addr_d    = cpu_req_addr[ADDR_W*int'(winner) +: ADDR_W];
                    payload_d = cpu_req_payload[DATA_W*int'(winner) +: DATA_W];
                    src_d     = SRC_W'(winner);
                    rr_ptr_d  = (winner == PTR_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
                    if (win_type == TYPE_READ || win_type == TYPE_WRITE) begin
                        state_d = ISSUE;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
                if (mem_resp_valid) begin
                    err_resp_d = 1'b1;
                end
            end
            ISSUE: begin
                // Writes are posted; only reads wait for a tagged response.
                if (mem_req_ready) begin
                    state_d = (type_q == TYPE_WRITE) ? IDLE : WAIT_RESP;
                end
                if (mem_resp_valid) begin
                    err_resp_d = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    if (mem_resp_source == src_q) begin
                        resp_valid_d[src_q[PTR_W-1:0]] = 1'b1;
                        resp_payload_d = mem_resp_payload;
                        state_d        = IDLE;
                    end else begin
                        err_resp_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            type_q         <= '0;
            addr_q         <= '0;
            payload_q      <= '0;
            src_q          <= '0;
            resp_valid_q   <= '0;
            resp_payload_q <= '0;
            err_cmd_q      <= 1'b0;
            err_resp_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            type_q         <= type_d;
            addr_q         <= addr_d;
            payload_q      <= payload_d;
            src_q          <= src_d;
            resp_valid_q   <= resp_valid_d;
            resp_payload_q <= resp_payload_d;
            err_cmd_q      <= err_cmd_d;
            err_resp_q     <= err_resp_d;
        end
    end

    assign mem_req_valid    = (state_q == ISSUE);
    assign mem_req_type     = type_q;
    assign mem_req_addr     = addr_q;
    assign mem_req_payload  = payload_q;
    assign mem_req_source   = src_q;
    assign cpu_resp_valid   = resp_valid_q;
    assign cpu_resp_payload = resp_payload_q;
    assign busy             = (state_q != IDLE);
    assign err_bad_cmd      = err_cmd_q;
    assign err_bad_resp     = err_resp_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected DRAM packets and CPU responses are
// queued as stimulus is driven and checked by a negedge monitor as the DUT produces them.
module tb_mem_bus_arbiter;
    localparam int NP = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NP-1:0]   cpu_req_valid = '0;
    logic [NP-1:0]   cpu_req_ready;
    logic [2*NP-1:0] cpu_req_type = '0;
    logic [AW*NP-1:0] cpu_req_addr = '0;
    logic [DW*NP-1:0] cpu_req_payload = '0;
    logic [NP-1:0]   cpu_resp_valid;
    logic [DW-1:0]   cpu_resp_payload;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b1;
    logic [1:0]      mem_req_type;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_payload;
    logic [SW-1:0]   mem_req_source;
    logic            mem_resp_valid = 1'b0;
    logic [DW-1:0]   mem_resp_payload = '0;
    logic [SW-1:0]   mem_resp_source = '0;
    logic            busy;
    logic            err_bad_cmd;
    logic            err_bad_resp;

    typedef struct {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } mem_pkt_t;

    typedef struct {
        logic [NP-1:0] mask;
        logic [DW-1:0] data;
    } resp_t;

    mem_pkt_t exp_mem[$];
    resp_t    exp_resp[$];
    int       grant_log[$];
    mem_pkt_t mon_mem;
    resp_t    mon_resp;
    int       errors = 0;
    int       checks = 0;
    int       resp_pulses = 0;

    mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .SRC_W(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_type(cpu_req_type), .cpu_req_addr(cpu_req_addr),
        .cpu_req_payload(cpu_req_payload),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_payload(cpu_resp_payload),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
        .mem_req_payload(mem_req_payload), .mem_req_source(mem_req_source),
        .mem_resp_valid(mem_resp_valid), .mem_resp_payload(mem_resp_payload),
        .mem_resp_source(mem_resp_source),
        .busy(busy), .err_bad_cmd(err_bad_cmd), .err_bad_resp(err_bad_resp)
    );

    always #5 clk = ~clk;

    // Negedge monitor: logs grants and scores every DRAM issue and CPU response pulse.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int p = 0; p < NP; p++) begin
                if (cpu_req_valid[p] === 1'b1 && cpu_req_ready[p] === 1'b1) grant_log.push_back(p);
            end
            if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
                checks++;
                if (exp_mem.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL mem_pkt_unexpected: got type=%b addr=%h src=%0d, required no packet",
                             mem_req_type, mem_req_addr, mem_req_source);
                end else begin
                    mon_mem = exp_mem.pop_front();
                    if (mem_req_type !== mon_mem.typ || mem_req_addr !== mon_mem.addr ||
                        mem_req_payload !== mon_mem.data || mem_req_source !== mon_mem.src) begin
                        errors++;
                        $display("[TB] FAIL mem_pkt: got type=%b addr=%h data=%h src=%0d, required type=%b addr=%h data=%h src=%0d",
                                 mem_req_type, mem_req_addr, mem_req_payload, mem_req_source,
                                 mon_mem.typ, mon_mem.addr, mon_mem.data, mon_mem.src);
                    end
                end
            end
            if (cpu_resp_valid !== '0) begin
                resp_pulses++;
                checks++;
                if (exp_resp.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cpu_resp_unexpected: got mask=%b data=%h, required no pulse",
                             cpu_resp_valid, cpu_resp_payload);
                end else begin
                    mon_resp = exp_resp.pop_front();
                    if (cpu_resp_valid !== mon_resp.mask || cpu_resp_payload !== mon_resp.data) begin
                        errors++;
                        $display("[TB] FAIL cpu_resp: got mask=%b data=%h, required mask=%b data=%h",
                                 cpu_resp_valid, cpu_resp_payload, mon_resp.mask, mon_resp.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req_valid[p]            = 1'b1;
        cpu_req_type[2*p +: 2]      = t;
        cpu_req_addr[AW*p +: AW]    = a;
        cpu_req_payload[DW*p +: DW] = d;
    endtask

    task automatic clr_req(input int p);
        cpu_req_valid[p] = 1'b0;
    endtask

    task automatic push_mem(input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        mem_pkt_t m;
        m.typ = t; m.addr = a; m.data = d; m.src = s;
        exp_mem.push_back(m);
    endtask

    task automatic push_resp(input logic [NP-1:0] mask, input logic [DW-1:0] d);
        resp_t r;
        r.mask = mask; r.data = d;
        exp_resp.push_back(r);
    endtask

    task automatic do_reset();
        cpu_req_valid  = '0;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        reset_n        = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Holds a request until the port is granted; returns just after the handshake edge.
    task automatic send_req(input int p, input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit granted;
        granted = 1'b0;
        set_req(p, t, a, d);
        for (int n = 0; n < 20 && !granted; n++) begin
            #1;
            if (cpu_req_ready[p] === 1'b1) granted = 1'b1;
            tick();
        end
        clr_req(p);
        checks++;
        if (!granted) begin
            errors++;
            $display("[TB] FAIL grant_timeout: port %0d got no grant in 20 cycles, required a grant", p);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({busy, mem_req_valid, cpu_resp_valid, cpu_req_ready, err_bad_cmd, err_bad_resp} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got busy=%b mreq_v=%b resp_v=%b ready=%b errc=%b errr=%b, required all 0",
                     busy, mem_req_valid, cpu_resp_valid, cpu_req_ready, err_bad_cmd, err_bad_resp);
        end
        checks++;
        if ({mem_req_type, mem_req_addr, mem_req_payload, mem_req_source, cpu_resp_payload} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_fields: got type=%b addr=%h data=%h src=%h rdata=%h, required all 0",
                     mem_req_type, mem_req_addr, mem_req_payload, mem_req_source, cpu_resp_payload);
        end
    endtask

    task automatic test_write();
        push_mem(2'b10, 64'h100, 64'h1122334455667788, 8'd0);
        set_req(0, 2'b10, 64'h100, 64'h1122334455667788);
        #1;
        checks++;
        if (cpu_req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL write_grant: got ready=%b, required 0001", cpu_req_ready);
        end
        tick();
        clr_req(0);
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || busy !== 1'b1 || mem_req_type !== 2'b10 ||
            mem_req_addr !== 64'h100 || mem_req_source !== 8'd0) begin
            errors++;
            $display("[TB] FAIL write_issue: got v=%b busy=%b type=%b addr=%h src=%0d, required v=1 busy=1 type=10 addr=100 src=0",
                     mem_req_valid, busy, mem_req_type, mem_req_addr, mem_req_source);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_done: got busy=%b v=%b, required 0 0", busy, mem_req_valid);
        end
    endtask

    task automatic test_read();
        int p0;
        push_mem(2'b01, 64'h40, 64'h0, 8'd2);
        push_resp(4'b0100, 64'hDEADBEEF);
        send_req(2, 2'b01, 64'h40, 64'h0);
        tick();
        checks++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_wait: got busy=%b v=%b, required busy=1 v=0", busy, mem_req_valid);
        end
        repeat (4) tick();
        p0 = resp_pulses;
        mem_resp_valid   = 1'b1;
        mem_resp_source  = 8'd2;
        mem_resp_payload = 64'hDEADBEEF;
        #1;
        checks++;
        if (cpu_resp_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL read_early: got resp_v=%b, required 0000", cpu_resp_valid);
        end
        tick();
        mem_resp_valid   = 1'b0;
        mem_resp_payload = '0;
        #1;
        checks++;
        if (cpu_resp_valid !== 4'b0100 || cpu_resp_payload !== 64'hDEADBEEF || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_resp: got resp_v=%b data=%h busy=%b, required 0100 deadbeef 0",
                     cpu_resp_valid, cpu_resp_payload, busy);
        end
        tick();
        checks++;
        if (cpu_resp_valid !== 4'b0000 || cpu_resp_payload !== 64'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_hold: got resp_v=%b data=%h, required 0000 deadbeef", cpu_resp_valid, cpu_resp_payload);
        end
        tick();
        checks++;
        if (resp_pulses - p0 !== 1) begin
            errors++;
            $display("[TB] FAIL read_pulse_count: got %0d pulses, required 1", resp_pulses - p0);
        end
    endtask

    task automatic test_round_robin();
        int order[6];
        int budget;
        order = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push_mem(2'b10, 64'h1000 + 64'(16 * order[k]), 64'hC0DE000000000000 + 64'(order[k]), SW'(order[k]));
        end
        grant_log.delete();
        for (int p = 0; p < NP; p++) begin
            set_req(p, 2'b10, 64'h1000 + 64'(16 * p), 64'hC0DE000000000000 + 64'(p));
        end
        budget = 0;
        while (grant_log.size() < 6 && budget < 60) begin
            tick();
            budget++;
        end
        cpu_req_valid = '0;
        budget = 0;
        while (exp_mem.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (grant_log.size() != 6 || exp_mem.size() != 0) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d grants, %0d pending packets, required 6 and 0",
                     grant_log.size(), exp_mem.size());
        end
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != order[k]) begin
                errors++;
                $display("[TB] FAIL rr_order[%0d]: got port %0d, required port %0d", k, grant_log[k], order[k]);
            end
        end
    endtask

    task automatic test_stall();
        push_mem(2'b10, 64'h200, 64'h5555AAAA5555AAAA, 8'd3);
        mem_req_ready = 1'b0;
        send_req(3, 2'b10, 64'h200, 64'h5555AAAA5555AAAA);
        set_req(0, 2'b10, 64'h999, 64'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (mem_req_valid !== 1'b1 || cpu_req_ready !== 4'b0000 || mem_req_type !== 2'b10 ||
                mem_req_addr !== 64'h200 || mem_req_payload !== 64'h5555AAAA5555AAAA || mem_req_source !== 8'd3) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b ready=%b type=%b addr=%h data=%h src=%0d, required v=1 ready=0000 type=10 addr=200 data=5555aaaa5555aaaa src=3",
                         k, mem_req_valid, cpu_req_ready, mem_req_type, mem_req_addr, mem_req_payload, mem_req_source);
            end
            tick();
        end
        clr_req(0);
        mem_req_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || exp_mem.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_release: got busy=%b pending=%0d, required busy=0 pending=0", busy, exp_mem.size());
        end
    endtask

    task automatic test_bad_resp();
        checks++;
        if (err_bad_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_resp_pre: got err_bad_resp=%b, required 0", err_bad_resp);
        end
        push_mem(2'b01, 64'h80, 64'h0, 8'd1);
        push_resp(4'b0010, 64'hCAFEF00D);
        send_req(1, 2'b01, 64'h80, 64'h0);
        tick();
        mem_resp_valid = 1'b1; mem_resp_source = 8'd3; mem_resp_payload = 64'hBAD;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (err_bad_resp !== 1'b1 || cpu_resp_valid !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_resp_tag: got err=%b resp_v=%b busy=%b, required 1 0000 1", err_bad_resp, cpu_resp_valid, busy);
        end
        tick();
        mem_resp_valid = 1'b1; mem_resp_source = 8'd1; mem_resp_payload = 64'hCAFEF00D;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (cpu_resp_valid !== 4'b0010 || cpu_resp_payload !== 64'hCAFEF00D || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_resp_recover: got resp_v=%b data=%h busy=%b, required 0010 cafef00d 0",
                     cpu_resp_valid, cpu_resp_payload, busy);
        end
        tick();
        mem_resp_valid = 1'b1; mem_resp_source = 8'd0; mem_resp_payload = 64'h77;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (err_bad_resp !== 1'b1 || busy !== 1'b0 || cpu_resp_valid !== 4'b0000 || cpu_resp_payload !== 64'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL bad_resp_idle: got err=%b busy=%b resp_v=%b data=%h, required 1 0 0000 cafef00d",
                     err_bad_resp, busy, cpu_resp_valid, cpu_resp_payload);
        end
    endtask

    task automatic test_bad_cmd_and_reset();
        do_reset();
        set_req(1, 2'b11, 64'h300, 64'hFFFF);
        #1;
        checks++;
        if (cpu_req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bad_cmd_grant: got ready=%b, required 0010", cpu_req_ready);
        end
        tick();
        clr_req(1);
        #1;
        checks++;
        if (err_bad_cmd !== 1'b1 || mem_req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_cmd_flag: got errc=%b v=%b busy=%b, required 1 0 0", err_bad_cmd, mem_req_valid, busy);
        end
        tick();
        checks++;
        if (err_bad_cmd !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_cmd_sticky: got errc=%b v=%b, required 1 0", err_bad_cmd, mem_req_valid);
        end
        push_mem(2'b01, 64'h400, 64'h0, 8'd0);
        send_req(0, 2'b01, 64'h400, 64'h0);
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wait: got busy=%b v=%b, required busy=1 v=0", busy, mem_req_valid);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if ({busy, mem_req_valid, cpu_resp_valid, err_bad_cmd, err_bad_resp, mem_req_addr, mem_req_source} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid: got busy=%b v=%b resp_v=%b errc=%b errr=%b addr=%h src=%0d, required all 0",
                     busy, mem_req_valid, cpu_resp_valid, err_bad_cmd, err_bad_resp, mem_req_addr, mem_req_source);
        end
        mem_resp_valid = 1'b1; mem_resp_source = 8'd0; mem_resp_payload = 64'h1234;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (err_bad_resp !== 1'b1 || cpu_resp_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_late_resp: got errr=%b resp_v=%b busy=%b, required 1 0000 0", err_bad_resp, cpu_resp_valid, busy);
        end
        tick();
    endtask

    initial begin
        $display("[TB] starting mem_bus_arbiter bench");
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_stall();
        test_bad_resp();
        test_bad_cmd_and_reset();
        tick();
        checks++;
        if (exp_mem.size() != 0 || exp_resp.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d packets and %0d responses pending, required 0 and 0",
                     exp_mem.size(), exp_resp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
